// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for mem_arbiter.
//   - arbiter state and owner encodings
//   - memory request payload carried from the owning cache to memory
package mem_arb_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned MEM_LAT_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        DRAIN
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_e;

    typedef struct packed {
        logic              en;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rd_outstanding_ctr.sv
// rd_outstanding_ctr: counts memory reads issued but not yet returned.
//   clk, rst_n   : clock, async active-low reset
//   inc_i        : a read was issued this cycle
//   dec_i        : read data returned this cycle
//   zero_o       : nothing outstanding now
//   next_zero_o  : nothing outstanding after this cycle
// Saturates at 0 and at MAX; a return seen at 0 is ignored so it cannot
// cancel an issue in the same cycle.
module rd_outstanding_ctr #(
    parameter int unsigned MAX = 4,
    parameter int unsigned W   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic next_zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         dec_ok;
    logic         inc_ok;

    // Next count; simultaneous inc/dec leaves the count unchanged.
    always_comb begin
        dec_ok = dec_i && (cnt_q != '0);
        inc_ok = inc_i && ((cnt_q != W'(MAX)) || dec_ok);
        cnt_d  = cnt_q;
        if (inc_ok && !dec_ok) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o      = (cnt_q == '0);
    assign next_zero_o = (cnt_d == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory between the I-cache and D-cache.
// Ownership is granted per transaction; the owner's request is forwarded to
// memory combinationally and read returns are steered back to the cache that
// issued them, including returns that arrive after the owner has released.
//   clk, rst_n                      : clock, async active-low reset
//   i_req, i_addr                   : I-cache read request / address
//   i_gnt, i_rdata, i_valid         : I-cache grant / read data / data valid
//   d_rd, d_wr, d_addr, d_wdata     : D-cache read, write, address, write data
//   d_gnt, d_rdata, d_valid         : D-cache grant / read data / data valid
//   mem_enable, mem_wr, mem_addr,
//   mem_data_in                     : request to memory
//   mem_data_out, mem_data_valid    : read return from memory
// Build option: MEM_ARB_RR_EN selects round-robin on simultaneous requests
// (side not served last wins); otherwise D always beats I.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_data_valid
);

    arb_state_e state_q;
    arb_state_e state_d;
    owner_e     owner_q;
    owner_e     owner_d;
    mem_req_t   req;
    logic       d_req;
    logic       pick_d;
    logic       cnt_zero;
    logic       cnt_next_zero;

    assign d_req = d_rd | d_wr;

`ifdef MEM_ARB_RR_EN
    logic last_d_q;
    logic last_d_d;

    // On a tie, D wins only if I was served last.
    assign pick_d = d_req & (~i_req | ~last_d_q);
`else
    assign pick_d = d_req;
`endif

    // Forward the owner's request; the non-owner's address is ignored.
    always_comb begin
        req       = '0;
        req.addr  = i_addr;
        req.wdata = d_wdata;
        case (state_q)
            GRANT_I: begin
                req.en = i_req;
            end
            GRANT_D: begin
                req.en   = d_req;
                req.wr   = d_wr;
                req.addr = d_addr;
            end
            default: ;
        endcase
    end

    rd_outstanding_ctr #(
        .MAX (MEM_LAT),
        .W   (CNT_W)
    ) u_rd_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (req.en & ~req.wr),
        .dec_i       (mem_data_valid),
        .zero_o      (cnt_zero),
        .next_zero_o (cnt_next_zero)
    );

    // Next state / owner. Owner is kept through DRAIN so late returns route.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
`ifdef MEM_ARB_RR_EN
        last_d_d = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d  = GRANT_D;
                    owner_d  = OWN_D;
`ifdef MEM_ARB_RR_EN
                    last_d_d = 1'b1;
`endif
                end else if (i_req) begin
                    state_d  = GRANT_I;
                    owner_d  = OWN_I;
`ifdef MEM_ARB_RR_EN
                    last_d_d = 1'b0;
`endif
                end
            end
            GRANT_I: begin
                if (!i_req) begin
                    state_d = cnt_next_zero ? IDLE : DRAIN;
                    if (cnt_next_zero) begin
                        owner_d = OWN_NONE;
                    end
                end
            end
            GRANT_D: begin
                if (!d_req) begin
                    state_d = cnt_next_zero ? IDLE : DRAIN;
                    if (cnt_next_zero) begin
                        owner_d = OWN_NONE;
                    end
                end
            end
            DRAIN: begin
                if (cnt_next_zero) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b1;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`endif

    assign i_gnt       = (state_q == GRANT_I);
    assign d_gnt       = (state_q == GRANT_D);

    assign mem_enable  = req.en;
    assign mem_wr      = req.wr;
    assign mem_addr    = req.addr;
    assign mem_data_in = req.wdata;

    // Returns seen with nothing outstanding are stray and dropped.
    assign i_valid     = mem_data_valid & ~cnt_zero & (owner_q == OWN_I);
    assign d_valid     = mem_data_valid & ~cnt_zero & (owner_q == OWN_D);
    assign i_rdata     = mem_data_out;
    assign d_rdata     = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked every cycle against a transaction-level model of the arbiter and a
// fixed-latency memory in the bench.
module tb_mem_arbiter;

    localparam int unsigned MEM_LAT = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int          RING    = 8;
    localparam int          NONE    = 0;
    localparam int          SI      = 1;
    localparam int          SD      = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_gnt;
    logic [15:0] i_rdata;
    logic        i_valid;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic [15:0] d_rdata;
    logic        d_valid;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;

    always #5 clk = ~clk;

    mem_arbiter #(
        .MEM_LAT (MEM_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_gnt          (i_gnt),
        .i_rdata        (i_rdata),
        .i_valid        (i_valid),
        .d_rd           (d_rd),
        .d_wr           (d_wr),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_gnt          (d_gnt),
        .d_rdata        (d_rdata),
        .d_valid        (d_valid),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_data_valid (mem_data_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Bench memory (driven by DUT outputs) and the model's own view of memory.
    logic [15:0] env_mem [int];
    logic [15:0] ref_mem [int];
    logic        ret_v [RING];
    logic [15:0] ret_d [RING];
    int          cyc;

    function automatic logic [15:0] env_rd(input logic [15:0] a);
        return env_mem.exists(int'(a)) ? env_mem[int'(a)] : (a ^ 16'hA5C3);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : (a ^ 16'hA5C3);
    endfunction

    // Arbiter model: who holds the grant, whether we wait for returns, and
    // the data each outstanding read should return, in issue order.
    int          m_gnt;
    int          m_holder;
    int          m_last;
    bit          m_drain;
    logic [15:0] m_q [$];

    // Requester state for the next cycle.
    logic        n_i_req, n_d_rd, n_d_wr;
    logic [15:0] n_i_addr, n_d_addr, n_d_wdata;
    int          i_left, d_left;
    bit          auto_gen, spur_en;

    // Observed outputs of the last cycle, for directed timing checks.
    logic        o_ig, o_dg, o_iv, o_dv, o_en, o_wr;
    logic [15:0] o_di, o_dr;

    task automatic start_i(input logic [15:0] a, input int n);
        n_i_req  = 1'b1;
        n_i_addr = a;
        i_left   = n;
    endtask

    task automatic start_d_rd(input logic [15:0] a, input int n);
        n_d_rd   = 1'b1;
        n_d_addr = a;
        d_left   = n;
    endtask

    task automatic start_d_wr(input logic [15:0] a, input logic [15:0] w);
        n_d_wr    = 1'b1;
        n_d_addr  = a;
        n_d_wdata = w;
    endtask

    task automatic model_reset();
        m_gnt    = NONE;
        m_holder = NONE;
        m_last   = SD;
        m_drain  = 1'b0;
        m_q.delete();
    endtask

    task automatic run_cycle();
        int          slot, g, win, rslot;
        logic        mv, exp_en, exp_wr, ret, issue, want_i, want_d;
        logic [15:0] md, exp_addr, exp_data;

        @(posedge clk);
        #1;
        i_req   = n_i_req;
        i_addr  = n_i_addr;
        d_rd    = n_d_rd;
        d_wr    = n_d_wr;
        d_addr  = n_d_addr;
        d_wdata = n_d_wdata;
        slot = cyc % RING;
        mv = ret_v[slot];
        md = ret_d[slot];
        ret_v[slot] = 1'b0;
        if (!mv && spur_en && m_gnt == NONE && !m_drain && m_q.size() == 0
            && $urandom_range(0, 3) == 0) begin
            mv = 1'b1;
            md = 16'($urandom);
        end
        mem_data_valid = mv;
        mem_data_out   = md;
        #2;

        g        = m_gnt;
        exp_en   = (g == SI && i_req) || (g == SD && (d_rd || d_wr));
        exp_wr   = (g == SD) && d_wr;
        exp_addr = (g == SI) ? i_addr : d_addr;
        ret      = mv && (m_q.size() > 0);

        check("i_gnt", 32'(i_gnt), 32'(g == SI));
        check("d_gnt", 32'(d_gnt), 32'(g == SD));
        check("mem_enable", 32'(mem_enable), 32'(exp_en));
        check("mem_wr", 32'(mem_wr), 32'(exp_wr));
        if (exp_en) check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_wr) check("mem_data_in", 32'(mem_data_in), 32'(d_wdata));
        check("i_valid", 32'(i_valid), 32'(ret && m_holder == SI));
        check("d_valid", 32'(d_valid), 32'(ret && m_holder == SD));
        if (ret) begin
            exp_data = m_q.pop_front();
            if (m_holder == SI) check("i_rdata", 32'(i_rdata), 32'(exp_data));
            else                check("d_rdata", 32'(d_rdata), 32'(exp_data));
        end

        o_ig = i_gnt; o_dg = d_gnt; o_iv = i_valid; o_dv = d_valid;
        o_en = mem_enable; o_wr = mem_wr; o_di = mem_data_in; o_dr = d_rdata;

        // Memory reacts to what the DUT actually issued.
        if (mem_enable) begin
            if (mem_wr) begin
                env_mem[int'(mem_addr)] = mem_data_in;
            end else begin
                rslot = (cyc + int'(MEM_LAT)) % RING;
                ret_v[rslot] = 1'b1;
                ret_d[rslot] = env_rd(mem_addr);
            end
        end

        // Model advance.
        issue = exp_en && !exp_wr;
        if (exp_en && exp_wr) ref_mem[int'(d_addr)] = d_wdata;
        if (issue) m_q.push_back(ref_rd(exp_addr));
        if (g != NONE) begin
            if (!((g == SI) ? i_req : (d_rd || d_wr))) begin
                m_drain = (m_q.size() != 0);
                m_gnt   = NONE;
            end
        end else if (m_drain) begin
            if (m_q.size() == 0) m_drain = 1'b0;
        end else begin
            want_i = i_req;
            want_d = d_rd || d_wr;
            win    = NONE;
            if (want_i && want_d) begin
`ifdef MEM_ARB_RR_EN
                win = (m_last == SD) ? SI : SD;
`else
                win = SD;
`endif
            end else if (want_d) begin
                win = SD;
            end else if (want_i) begin
                win = SI;
            end
            if (win != NONE) begin
                m_gnt    = win;
                m_holder = win;
                m_last   = win;
            end
        end

        // Requesters: hold until their transaction has been issued.
        if (i_req && g == SI) begin
            i_left--;
            n_i_addr = i_addr + 16'd2;
            if (i_left <= 0) n_i_req = 1'b0;
        end
        if ((d_rd || d_wr) && g == SD) begin
            if (d_wr) begin
                n_d_wr = 1'b0;
            end else begin
                d_left--;
                n_d_addr = d_addr + 16'd2;
                if (d_left <= 0) n_d_rd = 1'b0;
            end
        end
        if (auto_gen) begin
            if (!n_i_req && !i_req && $urandom_range(0, 3) == 0)
                start_i(16'($urandom_range(0, 31) * 16), int'($urandom_range(1, 8)));
            if (!n_d_rd && !n_d_wr && !d_rd && !d_wr && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 2) == 0)
                    start_d_wr(16'($urandom_range(0, 255) * 2), 16'($urandom));
                else
                    start_d_rd(16'($urandom_range(0, 31) * 16), int'($urandom_range(1, 8)));
            end
        end
        cyc++;
    endtask

    initial begin
        int first_ig, first_dg, first_iv, last_iv, last_dv, n_iv, n_dv, n_en, n_wr, igc, dgc;

        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0; d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        mem_data_valid = 1'b0; mem_data_out = '0;
        n_i_req = 1'b0; n_d_rd = 1'b0; n_d_wr = 1'b0;
        n_i_addr = '0; n_d_addr = '0; n_d_wdata = '0;
        i_left = 0; d_left = 0; auto_gen = 1'b0; spur_en = 1'b0; cyc = 0;
        for (int k = 0; k < RING; k++) begin
            ret_v[k] = 1'b0;
            ret_d[k] = '0;
        end
        model_reset();

        #2;
        check("rst_i_gnt", 32'(i_gnt), 0);
        check("rst_d_gnt", 32'(d_gnt), 0);
        check("rst_mem_enable", 32'(mem_enable), 0);
        check("rst_mem_wr", 32'(mem_wr), 0);
        check("rst_i_valid", 32'(i_valid), 0);
        check("rst_d_valid", 32'(d_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Collision straight after reset (last served = D); loser waits for drain.
        start_i(16'h0200, 2);
        start_d_rd(16'h0080, 2);
        first_ig = -1; first_dg = -1; last_dv = -1; n_dv = 0;
        for (int k = 0; k < 20; k++) begin
            run_cycle();
            if (o_ig && first_ig < 0) first_ig = k;
            if (o_dg && first_dg < 0) first_dg = k;
            if (o_dv) begin last_dv = k; n_dv++; end
        end
        check("collide_d_valid_cnt", 32'(n_dv), 2);
`ifdef MEM_ARB_RR_EN
        check("collide_rr_i_gnt", 32'(first_ig), 1);
        check("collide_rr_d_gnt", 32'(first_dg), 8);
`else
        check("collide_d_gnt", 32'(first_dg), 1);
        check("collide_i_gnt", 32'(first_ig), 8);
        check("drain_order", 32'(first_ig > last_dv), 1);
`endif

        // Lone 8-word I fill.
        start_i(16'h0000, 8);
        first_ig = -1; first_iv = -1; last_iv = -1; n_iv = 0; n_dv = 0; n_en = 0;
        for (int k = 0; k < 16; k++) begin
            run_cycle();
            if (o_ig && first_ig < 0) first_ig = k;
            if (o_iv) begin
                if (first_iv < 0) first_iv = k;
                last_iv = k;
                n_iv++;
            end
            if (o_dv) n_dv++;
            if (o_en) n_en++;
        end
        check("fill_i_gnt", 32'(first_ig), 1);
        check("fill_first_valid", 32'(first_iv), 5);
        check("fill_last_valid", 32'(last_iv), 12);
        check("fill_valid_cnt", 32'(n_iv), 8);
        check("fill_enable_cnt", 32'(n_en), 8);
        check("fill_no_d_valid", 32'(n_dv), 0);

        // D write then read-back of the same word.
        start_d_wr(16'h0040, 16'hBEEF);
        n_wr = 0;
        for (int k = 0; k < 4; k++) begin
            run_cycle();
            if (o_wr) begin
                n_wr++;
                check("wr_data", 32'(o_di), 32'h0000BEEF);
            end
        end
        check("wr_pulses", 32'(n_wr), 1);
        start_d_rd(16'h0040, 1);
        n_dv = 0;
        for (int k = 0; k < 8; k++) begin
            run_cycle();
            if (o_dv) begin
                n_dv++;
                check("rd_after_wr", 32'(o_dr), 32'h0000BEEF);
            end
        end
        check("rd_after_wr_cnt", 32'(n_dv), 1);

        // Starvation: D re-requests after a one-cycle gap, I always waiting.
        start_i(16'h0180, 2);
        start_d_rd(16'h0100, 1);
        igc = 0; dgc = 0;
        for (int k = 0; k < 100; k++) begin
            run_cycle();
            if (o_ig) igc++;
            if (o_dg) dgc++;
            if (!n_d_rd && !d_rd) start_d_rd(16'h0100, 1);
            if (!n_i_req && !i_req) start_i(16'h0180, 2);
        end
        check("starve_d_served", 32'(dgc > 0), 1);
`ifdef MEM_ARB_RR_EN
        check("starve_rr_i_served", 32'(igc > 0), 1);
`else
        check("starve_i_never", 32'(igc), 0);
`endif
        for (int k = 0; k < 30; k++) run_cycle();

        // Randomized traffic with stray returns while idle.
        auto_gen = 1'b1;
        spur_en  = 1'b1;
        for (int k = 0; k < 3000; k++) run_cycle();
        auto_gen = 1'b0;
        spur_en  = 1'b0;
        for (int k = 0; k < 40; k++) run_cycle();

        // Async reset in the middle of a fill; stale returns must be dropped.
        start_i(16'h0300, 8);
        for (int k = 0; k < 5; k++) run_cycle();
        #1;
        rst_n   = 1'b0;
        i_req   = 1'b0;
        n_i_req = 1'b0;
        i_left  = 0;
        #1;
        check("arst_i_gnt", 32'(i_gnt), 0);
        check("arst_d_gnt", 32'(d_gnt), 0);
        check("arst_mem_enable", 32'(mem_enable), 0);
        check("arst_i_valid", 32'(i_valid), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_iv = 0;
        for (int k = 0; k < 10; k++) begin
            run_cycle();
            if (o_iv || o_dv) n_iv++;
        end
        check("post_rst_no_valid", 32'(n_iv), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
